// File: rtl/uart_pkg.sv
// Shared UART frame definitions: frame-state encoding, data width and the parity rule
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  // mode = 1 gives odd parity (data + parity carries an odd number of ones).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: line synchronizer, frame FSM sampling at bit centres, and the
// received-byte / error registers. state_dbg exposes the FSM state.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES  = 5208,
  parameter int PARITY_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 err,
  output logic [2:0]           state_dbg
);

  localparam int         CNT_W    = $clog2(BIT_CYCLES);
  localparam int         HALF     = BIT_CYCLES / 2;
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);
  localparam logic       MODE     = (PARITY_MODE != 0);

  frame_state_t         state, state_next;
  logic                 rxd_meta, line, armed, par_rx;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shift;
  logic                 half_tick, bit_tick, sample;

  assign half_tick = (cnt == CNT_W'(HALF - 1));
  assign bit_tick  = (cnt == CNT_W'(BIT_CYCLES - 1));
  assign sample    = (state == START) ? half_tick : bit_tick;
  assign state_dbg = state;

  // Idle line is high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      line     <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      line     <= rxd_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (armed && !line) state_next = START;
      START:   if (half_tick) state_next = line ? IDLE : DATA;
      DATA:    if (bit_tick && idx == LAST_IDX) state_next = PARITY;
      PARITY:  if (bit_tick) state_next = STOP;
      STOP:    if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // armed stays low after a frame with a low stop bit until the line is seen high again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      par_rx <= 1'b0;
      data   <= '0;
      err    <= 1'b0;
      armed  <= 1'b1;
    end else begin
      if (line) armed <= 1'b1;
      if (state == IDLE) begin
        cnt <= '0;
        idx <= '0;
      end else if (sample) begin
        cnt <= '0;
        case (state)
          DATA: begin
            shift <= {line, shift[DATA_BITS-1:1]};
            idx   <= idx + 3'd1;
          end
          PARITY: par_rx <= line;
          STOP: begin
            data <= shift;
            err  <= (par_rx != parity_bit(shift, MODE)) || !line;
            if (!line) armed <= 1'b0;
          end
          default: ;
        endcase
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_trx_top.sv
// Board-level UART loopback: debounced centre button sends SW as one parity-protected
// frame; the receiver shows the last byte, busy flags and receive error on LEDs.
module uart_trx_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ        = 100000000,
  parameter int BAUD_RATE       = 19200,
  parameter int PARITY_MODE     = 1,
  parameter int DEBOUNCE_CYCLES = CLK_FREQ / 1000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  SW,
  input  logic        BTNC,
  input  logic        UART_TXD_IN,
  output logic        UART_RXD_OUT,
  output logic [15:0] LED,
  output logic        LED16_B,
  output logic        LED17_R,
  output logic        LED17_G
);

  localparam int         BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int         CNT_W      = $clog2(BIT_CYCLES);
  localparam int         DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0] LAST_IDX   = 3'(DATA_BITS - 1);
  localparam logic       MODE       = (PARITY_MODE != 0);

  logic clk, rst;
  assign clk = CLK100MHZ;
  assign rst = CPU_RESETN;

  logic            btn_meta, btn_sync, db_level, db_prev, send_pulse;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_meta <= BTNC;
      btn_sync <= btn_meta;
      db_prev  <= db_level;
      if (btn_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= btn_sync;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign send_pulse = db_level & ~db_prev;

  frame_state_t         tx_state, tx_next;
  logic [CNT_W-1:0]     tx_cnt;
  logic [2:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_tick, tx_line;

  assign tx_tick = (tx_cnt == CNT_W'(BIT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= IDLE;
    else     tx_state <= tx_next;
  end

  // Send pulses outside IDLE are ignored: the FSM only looks at them in IDLE.
  always_comb begin
    tx_next = tx_state;
    tx_line = 1'b1;
    unique case (tx_state)
      IDLE:   if (send_pulse) tx_next = START;
      START: begin
        tx_line = 1'b0;
        if (tx_tick) tx_next = DATA;
      end
      DATA: begin
        tx_line = tx_shift[0];
        if (tx_tick && tx_idx == LAST_IDX) tx_next = PARITY;
      end
      PARITY: begin
        tx_line = tx_par;
        if (tx_tick) tx_next = STOP;
      end
      STOP:    if (tx_tick) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else if (tx_state == IDLE) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      if (send_pulse) begin
        tx_shift <= SW;
        tx_par   <= parity_bit(SW, MODE);
      end
    end else if (tx_tick) begin
      tx_cnt <= '0;
      if (tx_state == DATA) begin
        tx_shift <= tx_shift >> 1;
        tx_idx   <= tx_idx + 3'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  assign UART_RXD_OUT = tx_line;
  assign LED16_B      = (tx_state != IDLE);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_err;
  logic [2:0]           rx_state_dbg;

  uart_rx_core #(
    .BIT_CYCLES  (BIT_CYCLES),
    .PARITY_MODE (PARITY_MODE)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (UART_TXD_IN),
    .data      (rx_data),
    .err       (rx_err),
    .state_dbg (rx_state_dbg)
  );

  assign LED     = {rx_data, SW};
  assign LED17_R = (rx_state_dbg != IDLE);
  assign LED17_G = rx_err;

endmodule

// File: tb/tb_uart_trx_top.sv
// Bench for uart_trx_top at a scaled clock (16 cycles per bit, 20-cycle debounce):
// loopback and externally driven frames checked against a frame-level reference model.
module tb_uart_trx_top;

  localparam int CLK_FREQ    = 307200;
  localparam int BAUD_RATE   = 19200;
  localparam int BIT         = CLK_FREQ / BAUD_RATE;
  localparam int PARITY_MODE = 1;
  localparam int DEB         = 20;
  localparam int TIMEOUT     = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw;
  logic        btnc;
  logic        drv_line;
  logic        loop_en;
  logic        rxd_in;
  logic        txd_out;
  logic [15:0] led;
  logic        b, r, g;

  int n_checks = 0;
  int n_errors = 0;
  int tx_frames = 0;
  logic busy_q = 1'b0;
  logic [8:0] exp_q[$];

  assign rxd_in = loop_en ? txd_out : drv_line;

  uart_trx_top #(
    .CLK_FREQ        (CLK_FREQ),
    .BAUD_RATE       (BAUD_RATE),
    .PARITY_MODE     (PARITY_MODE),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst),
    .SW           (sw),
    .BTNC         (btnc),
    .UART_TXD_IN  (rxd_in),
    .UART_RXD_OUT (txd_out),
    .LED          (led),
    .LED16_B      (b),
    .LED17_R      (r),
    .LED17_G      (g)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // counts transmitted frames by rising edges of the TX busy LED
  always @(negedge clk) begin
    busy_q <= b;
    if (b && !busy_q) tx_frames <= tx_frames + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference frame: start, data LSB first, parity making data+parity odd in odd mode, stop
  function automatic logic [10:0] frame_model(input logic [7:0] d, input logic bad_par,
                                              input logic bad_stop);
    logic [10:0] f;
    int ones;
    ones = $countones(d);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9]  = ((((ones + PARITY_MODE) % 2) == 1) ? 1'b1 : 1'b0) ^ bad_par;
    f[10] = ~bad_stop;
    return f;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((b || r) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (n >= TIMEOUT) ? 1 : 0, 0);
  endtask

  task automatic check_rx(input string tag);
    logic [8:0] e;
    e = exp_q.pop_front();
    check_eq({tag, "_data"}, led[15:8], e[7:0]);
    check_eq({tag, "_err"}, g, e[8]);
    check_eq({tag, "_rbusy"}, r, 0);
  endtask

  task automatic loop_byte(input logic [7:0] d, input string tag);
    int f0;
    f0 = tx_frames;
    loop_en = 1'b1;
    sw = d;
    exp_q.push_back({1'b0, d});
    btnc = 1'b1;
    cycles(40);
    btnc = 1'b0;
    wait_idle({tag, "_idle"});
    cycles(2);
    check_rx(tag);
    check_eq({tag, "_sw"}, led[7:0], d);
    check_eq({tag, "_frames"}, tx_frames - f0, 1);
    cycles(30);
  endtask

  task automatic ext_frame(input logic [7:0] d, input logic bp, input logic bs, input string tag);
    logic [10:0] f;
    f = frame_model(d, bp, bs);
    loop_en = 1'b0;
    exp_q.push_back({bp | bs, d});
    for (int k = 0; k < 11; k++) begin
      drv_line = f[k];
      cycles(BIT);
    end
    drv_line = 1'b1;
    cycles(BIT);
    wait_idle({tag, "_idle"});
    check_rx(tag);
  endtask

  task automatic capture_frame(input logic [7:0] d);
    logic [10:0] f;
    int n, hits, f0;
    f = frame_model(d, 1'b0, 1'b0);
    f0 = tx_frames;
    loop_en = 1'b1;
    sw = d;
    exp_q.push_back({1'b0, d});
    btnc = 1'b1;
    n = 0;
    while (txd_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("cap_start_timeout", (n >= 200) ? 1 : 0, 0);
    for (int k = 0; k < 11; k++) begin
      hits = 0;
      for (int c = 0; c < BIT; c++) begin
        if (txd_out == f[k]) hits++;
        if (k == 1 && c == 0) btnc = 1'b0;
        @(negedge clk);
      end
      check_eq($sformatf("cap_bit%0d_cycles", k), hits, BIT);
    end
    check_eq("cap_idle_after", txd_out, 1);
    wait_idle("cap_idle");
    cycles(2);
    check_rx("cap");
    check_eq("cap_frames", tx_frames - f0, 1);
    cycles(30);
  endtask

  initial begin
    int f0, n;
    logic seen;
    rst = 1'b1;
    sw = 8'h5A;
    btnc = 1'b0;
    drv_line = 1'b1;
    loop_en = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    check_eq("rst_txline", txd_out, 1);
    check_eq("rst_rxdata", led[15:8], 0);
    check_eq("rst_led_lo", led[7:0], 8'h5A);
    check_eq("rst_tbusy", b, 0);
    check_eq("rst_rbusy", r, 0);
    check_eq("rst_err", g, 0);

    loop_byte(8'h24, "lb24");
    loop_byte(8'h81, "lb81");
    loop_byte(8'h09, "lb09");
    loop_byte(8'h63, "lb63");

    capture_frame(8'hA5);

    // bouncing button: toggles faster than the debounce window, then held
    f0 = tx_frames;
    loop_en = 1'b1;
    sw = 8'h3C;
    exp_q.push_back({1'b0, 8'h3C});
    for (int i = 0; i < 8; i++) begin
      btnc = ~btnc;
      cycles(8);
    end
    check_eq("bounce_quiet", tx_frames - f0, 0);
    btnc = 1'b1;
    cycles(40);
    btnc = 1'b0;
    wait_idle("bounce_idle");
    cycles(60);
    check_rx("bounce");
    check_eq("bounce_frames", tx_frames - f0, 1);

    // second press while the transmitter is busy must be ignored
    f0 = tx_frames;
    sw = 8'hC7;
    exp_q.push_back({1'b0, 8'hC7});
    btnc = 1'b1; cycles(40);
    btnc = 1'b0; cycles(40);
    btnc = 1'b1; cycles(40);
    btnc = 1'b0;
    wait_idle("busy_idle");
    cycles(60);
    check_rx("busy");
    check_eq("busy_frames", tx_frames - f0, 1);

    ext_frame(8'h55, 1'b1, 1'b0, "badpar");

    // short low glitch: receiver starts, then abandons without touching data/error
    loop_en = 1'b0;
    seen = 1'b0;
    drv_line = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (r) seen = 1'b1;
      if (i == 4) drv_line = 1'b1;
      @(negedge clk);
    end
    cycles(20);
    check_eq("glitch_seen_busy", seen, 1);
    check_eq("glitch_rbusy", r, 0);
    check_eq("glitch_data", led[15:8], 8'h55);
    check_eq("glitch_err", g, 1);

    ext_frame(8'h55, 1'b0, 1'b0, "goodpar");
    ext_frame(8'h3C, 1'b0, 1'b1, "badstop");
    ext_frame(8'hE1, 1'b0, 1'b0, "afterstop");

    for (int i = 0; i < 10; i++) begin
      logic [7:0] rb;
      logic bp, bs;
      rb = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) loop_byte(rb, $sformatf("rnd%0d_lb", i));
      else ext_frame(rb, bp, bs, $sformatf("rnd%0d_ext", i));
    end

    // reset in the middle of a transmitted frame
    loop_en = 1'b1;
    sw = 8'h00;
    btnc = 1'b1;
    n = 0;
    while (!b && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_start_timeout", (n >= 200) ? 1 : 0, 0);
    btnc = 1'b0;
    cycles(20);
    check_eq("mid_line_low", txd_out, 0);
    rst = 1'b1;
    #2;
    check_eq("mid_rst_line", txd_out, 1);
    cycles(2);
    rst = 1'b0;
    f0 = tx_frames;
    cycles(2);
    check_eq("mid_line", txd_out, 1);
    check_eq("mid_tbusy", b, 0);
    check_eq("mid_rbusy", r, 0);
    check_eq("mid_data", led[15:8], 0);
    check_eq("mid_err", g, 0);
    cycles(11 * BIT);
    check_eq("mid_no_restart", tx_frames - f0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_trx_top.md
Name: uart_trx_top

Overview:
- Board-level UART loopback block. Debounces the centre button; on each press it transmits SW[7:0] as one parity-protected UART frame on UART_RXD_OUT.
- Simultaneously receives frames on UART_TXD_IN and shows the received byte, transmitter/receiver busy and receive error on LEDs.
- Sits at the top of the FPGA design; externally looped TX→RX in verification.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 19200, UART bit rate; BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer, 5208 at defaults).
- PARITY_MODE, 1, 1 = odd parity, 0 = even parity.
- DEBOUNCE_CYCLES, CLK_FREQ/1000, cycles (1 ms) the synchronized button must be stable before the debounced level changes.

Ports:
- CLK100MHZ  in  1  system clock, all logic on rising edge.
- CPU_RESETN  in  1  reset; one clock, reset is asynchronous and active-high (1 = reset).
- SW  in  8  byte to transmit.
- BTNC  in  1  raw send button, asynchronous, bouncy.
- UART_TXD_IN  in  1  serial receive line, asynchronous, idle high.
- UART_RXD_OUT  out  1  serial transmit line, idle high.
- LED  out  16  [7:0] = SW (combinational); [15:8] = last received byte.
- LED16_B  out  1  transmitter busy.
- LED17_R  out  1  receiver busy.
- LED17_G  out  1  receive error of last completed frame.

Behaviour:
- Reset values: UART_RXD_OUT=1, LED[15:8]=0, LED16_B=0, LED17_R=0, LED17_G=0; all counters 0; both FSMs IDLE.
- Reset mid-frame aborts the frame immediately; the line returns high.
- Input sync: BTNC and UART_TXD_IN each pass through a 2-flop synchronizer; the RX synchronizer resets to 1.
- Debouncer: counter clears whenever the synchronized input equals the debounced level. When they differ for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips.
- A one-cycle send pulse is generated on each debounced rising edge.
- Frame format: start(0), D0..D7 LSB first, parity, stop(1). Parity bit = ^data XOR PARITY_MODE, so odd mode makes the total count of ones in data+parity odd.
- TX FSM states IDLE → START → DATA(8 bits) → PARITY → STOP → IDLE. Each bit is held exactly BIT_CYCLES.
- TX: SW is sampled into a shift register on the send pulse.
- TX: LED16_B=1 from the cycle after the send pulse through the last STOP cycle.
- TX: a send pulse while busy is ignored.
- RX FSM states IDLE → START → DATA → PARITY → STOP → IDLE.
- RX IDLE: a synchronized line 0 enters START and LED17_R goes to 1.
- RX START: at BIT_CYCLES/2 the line is re-checked. If it is 1 (glitch), return to IDLE with no data or error update. Otherwise sample every further BIT_CYCLES at bit centres.
- RX stop-bit centre: data reg (LED[15:8]) is loaded with the received byte. LED17_G = (parity mismatch) OR (stop bit == 0). LED17_R drops to 0 in the same cycle.
- RX: the data register is loaded even on error. LED17_G holds until the next completed frame.
- RX: a line held low after a bad stop bit is not re-armed until it returns high.
- TX and RX run independently and may be active simultaneously.
- Loopback latency: from send pulse to LED[15:8] update ≈ 10.5×BIT_CYCLES + 2–3 sync cycles.

Decomposition:
- Shared package uart_pkg holds:
  - the frame-state enum (IDLE, START, DATA, PARITY, STOP);
  - the DATA_BITS=8 constant;
  - a parity function parity_bit(data, mode).
- One sub-module, uart_rx_core (synchronizer, RX FSM, data/error registers).
- Debouncer and transmitter are implemented inline in the top.

Test Plan:
- Reset: hold CPU_RESETN=1 for 2 cycles, release → UART_RXD_OUT=1, LED[15:8]=0, LED16_B=LED17_R=LED17_G=0.
- Loopback with UART_TXD_IN tied to UART_RXD_OUT, defaults: SW=8'h24, BTNC high 5 ms then low 5 ms → after busy lights clear, LED[15:8]=8'h24, LED17_G=0, LED[7:0]=8'h24.
- Three back-to-back loopback bytes 8'h81, 8'h09, 8'h63 → each matches, no error.
- Frame check with SW=8'hA5, odd parity: TX line shows bit sequence 0,1,0,1,0,0,1,0,1,1,1 with each bit 5208 cycles.
- Bounce: BTNC toggling every 100 µs for 800 µs then high → exactly one frame sent.
- Error injection: drive RX externally with a frame 8'h55 carrying the wrong parity bit → LED[15:8]=8'h55, LED17_G=1. A following correct frame clears LED17_G.
- Bad stop: stop bit 0 → LED17_G=1.
- Glitch: a 1000-cycle low pulse on UART_TXD_IN → LED17_R drops without a data or error update.
